// File: rtl/risc_v_pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Forward-select codes, the shadow-stage record and a write-match helper.
package risc_v_pipe_pkg;

    // Widest register address the shadow records can carry.
    localparam int REG_AW = 16;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_t;

    function automatic logic writes_reg(stage_t s, logic [REG_AW-1:0] r);
        return s.valid & s.regwrite & (s.rd != '0) & (s.rd == r);
    endfunction

endpackage

// File: rtl/risc_v_pipe_ctrl_fwd_select.sv
// Operand forward select for one EX source: EX/MEM beats MEM/WB, x0 never
// forwarded, register file when the EX slot is empty or the source unused.
module fwd_select
    import risc_v_pipe_pkg::*;
(
    input  logic              ex_valid,
    input  logic              use_rs,
    input  logic [REG_AW-1:0] rs,
    input  stage_t            mem,
    input  stage_t            wb,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (ex_valid && use_rs) begin
            if (writes_reg(mem, rs))
                sel = FWD_EXMEM;
            else if (writes_reg(wb, rs))
                sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/risc_v_pipe_ctrl.sv
// Load-use stall, branch flush and forwarding control over an EX/MEM/WB shadow pipe.
// Define PIPE_CTRL_PERF_CNT_EN to build the stall/flush/retire counters.
module risc_v_pipe_ctrl
    import risc_v_pipe_pkg::*;
#(
    parameter int AW    = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_taken,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    stage_t id_entry;
    stage_t ex;
    stage_t mem;
    stage_t wb;
    logic   load_use;
    logic   branch;

    always_comb begin
        id_entry          = '0;
        id_entry.valid    = id_valid;
        id_entry.rs1      = REG_AW'(id_rs1);
        id_entry.rs2      = REG_AW'(id_rs2);
        id_entry.use_rs1  = id_use_rs1;
        id_entry.use_rs2  = id_use_rs2;
        id_entry.rd       = REG_AW'(id_rd);
        id_entry.regwrite = id_regwrite;
        id_entry.memread  = id_memread;
    end

    assign load_use = id_valid & ex.valid & ex.memread & (ex.rd != '0)
                    & ((id_use_rs1 & (id_entry.rs1 == ex.rd))
                     | (id_use_rs2 & (id_entry.rs2 == ex.rd)));
    assign branch   = ex.valid & ex_branch_taken;

    // A taken branch squashes ID anyway, so it overrides the stall.
    assign pc_stall     = load_use & ~branch;
    assign if_id_stall  = load_use & ~branch;
    assign if_id_flush  = branch;
    assign id_ex_bubble = load_use | branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex  <= '0;
            mem <= '0;
            wb  <= '0;
        end else begin
            ex  <= (id_ex_bubble || !id_valid) ? '0 : id_entry;
            mem <= ex;
            wb  <= mem;
        end
    end

    assign ex_valid  = ex.valid;
    assign mem_valid = mem.valid;
    assign wb_valid  = wb.valid;

    fwd_select u_fwd_a (
        .ex_valid (ex.valid),
        .use_rs   (ex.use_rs1),
        .rs       (ex.rs1),
        .mem      (mem),
        .wb       (wb),
        .sel      (forward_a)
    );

    fwd_select u_fwd_b (
        .ex_valid (ex.valid),
        .use_rs   (ex.use_rs2),
        .rs       (ex.rs2),
        .mem      (mem),
        .wb       (wb),
        .sel      (forward_b)
    );

`ifdef PIPE_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            stall_cnt  <= stall_cnt + CNT_W'(pc_stall);
            flush_cnt  <= flush_cnt + CNT_W'(branch);
            retire_cnt <= retire_cnt + CNT_W'(wb.valid);
        end
    end
`else
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_risc_v_pipe_ctrl.sv
// Self-checking bench for risc_v_pipe_ctrl: directed hazard/forward/flush/reset
// scenarios plus randomized traffic against an instruction-history model.
module tb_risc_v_pipe_ctrl;

    localparam int AW    = 5;
    localparam int CNT_W = 32;
`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [AW-1:0]    id_rs1;
    logic [AW-1:0]    id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [AW-1:0]    id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             ex_branch_taken;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             ex_valid;
    logic             mem_valid;
    logic             wb_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] retire_cnt;

    risc_v_pipe_ctrl #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_regwrite     (id_regwrite),
        .id_memread      (id_memread),
        .ex_branch_taken (ex_branch_taken),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .ex_valid        (ex_valid),
        .mem_valid       (mem_valid),
        .wb_valid        (wb_valid),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .retire_cnt      (retire_cnt)
    );

    typedef struct {
        bit v;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        int rd;
        bit rw;
        bit mr;
    } ins_t;

    // hist[0] = EX, hist[1] = MEM, hist[2] = WB
    ins_t hist[$];
    int   m_stall;
    int   m_flush;
    int   m_retire;
    int   n_cmp;
    int   n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit m_branch();
        return hist[0].v && ex_branch_taken;
    endfunction

    function automatic bit m_hazard();
        ins_t e;
        e = hist[0];
        return id_valid && e.v && e.mr && e.rd != 0 &&
               ((id_use_rs1 && int'(id_rs1) == e.rd) ||
                (id_use_rs2 && int'(id_rs2) == e.rd));
    endfunction

    function automatic bit m_writes(ins_t s, int r);
        return s.v && s.rw && s.rd != 0 && s.rd == r;
    endfunction

    function automatic logic [1:0] m_fwd(bit use_it, int rs);
        if (!hist[0].v || !use_it) return 2'b00;
        if (m_writes(hist[1], rs)) return 2'b10;
        if (m_writes(hist[2], rs)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] m_cnt(int c);
        return PERF ? CNT_W'(c) : '0;
    endfunction

    task automatic model_reset();
        ins_t e;
        e = '{default: 0};
        hist.delete();
        repeat (3) hist.push_back(e);
        m_stall  = 0;
        m_flush  = 0;
        m_retire = 0;
    endtask

    task automatic set_id(bit v, int rs1, int rs2, bit u1, bit u2,
                          int rd, bit rw, bit mr, bit br);
        id_valid        = v;
        id_rs1          = AW'(rs1);
        id_rs2          = AW'(rs2);
        id_use_rs1      = u1;
        id_use_rs2      = u2;
        id_rd           = AW'(rd);
        id_regwrite     = rw;
        id_memread      = mr;
        ex_branch_taken = br;
        #1;
    endtask

    task automatic set_idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance the model by one clock using the currently driven ID inputs.
    task automatic tick();
        bit   haz;
        bit   br;
        ins_t n;
        haz = m_hazard();
        br  = m_branch();
        if (haz && !br) m_stall++;
        if (br) m_flush++;
        if (hist[2].v) m_retire++;
        n = '{default: 0};
        if (id_valid && !haz && !br)
            n = '{1, int'(id_rs1), int'(id_rs2), id_use_rs1, id_use_rs2,
                  int'(id_rd), id_regwrite, id_memread};
        hist.push_front(n);
        void'(hist.pop_back());
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_idle();
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        reset = 1'b1;
        set_id(1, 1, 2, 1, 1, 3, 1, 1, 1);
        model_reset();
        @(posedge clk);
        #2;
        obs = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
               forward_a, forward_b, ex_valid, mem_valid, wb_valid};
        n_cmp++;
        if (obs !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 0", obs);
        end
        n_cmp++;
        if ({stall_cnt, flush_cnt, retire_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_cnt: got %0d %0d %0d expected 0 0 0",
                     stall_cnt, flush_cnt, retire_cnt);
        end
        reset = 1'b0;
        set_idle();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0);
        n_cmp++;
        if (pc_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL lu_no_early_stall: got %b expected 0", pc_stall);
        end
        tick();
        set_id(1, 5, 7, 1, 1, 6, 1, 0, 0);
        n_cmp++;
        if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b1110) begin
            n_bad++;
            $display("FAIL lu_stall: got %b expected 1110",
                     {pc_stall, if_id_stall, id_ex_bubble, if_id_flush});
        end
        tick();
        n_cmp++;
        if (pc_stall !== 1'b0 || ex_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL lu_one_cycle: got stall=%b ex_valid=%b expected 0 0",
                     pc_stall, ex_valid);
        end
        tick();
        set_idle();
        n_cmp++;
        if ({forward_a, forward_b} !== 4'b0100) begin
            n_bad++;
            $display("FAIL lu_fwd: got %b_%b expected 01_00", forward_a, forward_b);
        end
        n_cmp++;
        if (stall_cnt !== m_cnt(1)) begin
            n_bad++;
            $display("FAIL lu_stall_cnt: got %0d expected %0d", stall_cnt, m_cnt(1));
        end
    endtask

    task automatic test_forwarding();
        set_id(1, 2, 3, 1, 1, 1, 1, 0, 0);
        tick();
        set_id(1, 1, 1, 1, 1, 4, 1, 0, 0);
        n_cmp++;
        if (pc_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL fwd_no_stall: got %b expected 0", pc_stall);
        end
        tick();
        set_idle();
        n_cmp++;
        if ({forward_a, forward_b} !== 4'b1010) begin
            n_bad++;
            $display("FAIL fwd_exmem: got %b_%b expected 10_10", forward_a, forward_b);
        end
        tick();
        set_id(1, 2, 3, 1, 1, 1, 1, 0, 0);
        tick();
        set_id(1, 2, 3, 1, 1, 9, 1, 0, 0);
        tick();
        set_id(1, 1, 8, 1, 0, 10, 1, 0, 0);
        tick();
        set_idle();
        n_cmp++;
        if ({forward_a, forward_b} !== 4'b0100) begin
            n_bad++;
            $display("FAIL fwd_memwb: got %b_%b expected 01_00", forward_a, forward_b);
        end
        tick();
    endtask

    task automatic test_x0();
        set_id(1, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        set_id(1, 0, 0, 1, 1, 11, 1, 0, 0);
        n_cmp++;
        if ({pc_stall, id_ex_bubble} !== 2'b00) begin
            n_bad++;
            $display("FAIL x0_no_stall: got %b expected 00", {pc_stall, id_ex_bubble});
        end
        tick();
        set_idle();
        n_cmp++;
        if ({forward_a, forward_b} !== 4'b0000) begin
            n_bad++;
            $display("FAIL x0_no_fwd: got %b_%b expected 00_00", forward_a, forward_b);
        end
        tick();
    endtask

    task automatic test_branch_vs_hazard();
        int seen;
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1, 0);
        tick();
        set_id(1, 5, 7, 1, 1, 6, 1, 0, 1);
        n_cmp++;
        if ({if_id_flush, id_ex_bubble, pc_stall, if_id_stall} !== 4'b1100) begin
            n_bad++;
            $display("FAIL br_wins: got %b expected 1100",
                     {if_id_flush, id_ex_bubble, pc_stall, if_id_stall});
        end
        tick();
        set_idle();
        seen = 0;
        repeat (5) begin
            if (wb_valid === 1'b1) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 1) begin
            n_bad++;
            $display("FAIL br_squash: got %0d retired expected 1", seen);
        end
        n_cmp++;
        if (flush_cnt !== m_cnt(1) || stall_cnt !== m_cnt(0)) begin
            n_bad++;
            $display("FAIL br_cnts: got flush=%0d stall=%0d expected %0d %0d",
                     flush_cnt, stall_cnt, m_cnt(1), m_cnt(0));
        end
    endtask

    task automatic test_reset_midstream();
        logic [10:0] obs;
        int          seen;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_id(1, 3, 4, 1, 1, i + 1, 1, 0, 0);
            tick();
        end
        set_id(1, 1, 2, 1, 1, 7, 1, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        obs = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
               forward_a, forward_b, ex_valid, mem_valid, wb_valid};
        n_cmp++;
        if (obs !== 11'd0 || {stall_cnt, flush_cnt, retire_cnt} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got %b cnt %0d expected all 0", obs, retire_cnt);
        end
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            set_id(1, 0, 0, 0, 0, i + 1, 1, 0, 0);
            if (wb_valid === 1'b1) seen++;
            tick();
        end
        set_idle();
        repeat (4) begin
            if (wb_valid === 1'b1) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 10) begin
            n_bad++;
            $display("FAIL rst_retire_seen: got %0d expected 10", seen);
        end
        n_cmp++;
        if (retire_cnt !== m_cnt(10)) begin
            n_bad++;
            $display("FAIL rst_retire_cnt: got %0d expected %0d", retire_cnt, m_cnt(10));
        end
    endtask

    task automatic test_random();
        logic [10:0] obs;
        logic [10:0] exp;
        bit          haz;
        bit          br;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0);
            haz = m_hazard();
            br  = m_branch();
            exp = {haz && !br, haz && !br, br, haz || br,
                   m_fwd(hist[0].u1, hist[0].rs1), m_fwd(hist[0].u2, hist[0].rs2),
                   hist[0].v, hist[1].v, hist[2].v};
            obs = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
                   forward_a, forward_b, ex_valid, mem_valid, wb_valid};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL rand_ctrl[%0d]: got %b expected %b", i, obs, exp);
            end
            n_cmp++;
            if ({stall_cnt, flush_cnt, retire_cnt} !==
                {m_cnt(m_stall), m_cnt(m_flush), m_cnt(m_retire)}) begin
                n_bad++;
                $display("FAIL rand_cnt[%0d]: got %0d %0d %0d expected %0d %0d %0d",
                         i, stall_cnt, flush_cnt, retire_cnt,
                         m_cnt(m_stall), m_cnt(m_flush), m_cnt(m_retire));
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        set_idle();
        model_reset();
        test_reset();
        test_load_use();
        test_forwarding();
        test_x0();
        test_branch_vs_hazard();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
